// File: rtl/timer_seq_master.sv
// Avalon-MM initiator that programs the interval timer, services its timeouts
// with tick pulses and a tick count, and reads back counter snapshots.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no sequence active, waiting for cmd_start
// WR_PL    | writing load[15:0] to period_l
// WR_PH    | writing load[31:16] to period_h
// WR_CTL   | writing control: start, continuous, ITO
// RUN      | timer running, watching irq / stop / snap
// WR_CLR   | clearing the timer status (timeout serviced)
// CLR_WAIT | letting the timer irq drop after the clear
// WR_STOP  | writing control: stop
// WR_SNAP  | write to snap_l to latch the counter
// RD_SL    | read snap_l
// RD_SL_W  | snap_l read data returning
// RD_SH    | read snap_h
// RD_SH_W  | snap_h read data returning
module timer_seq_master #(
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_start,
  input  logic [31:0]       cmd_period,
  input  logic              cmd_continuous,
  input  logic              cmd_stop,
  input  logic              cmd_snap,
  output logic [2:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [15:0]       avm_writedata,
  input  logic [15:0]       avm_readdata,
  input  logic              timer_irq,
  output logic              busy,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snap_value,
  output logic              snap_valid
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTL, RUN, WR_CLR, CLR_WAIT,
    WR_STOP, WR_SNAP, RD_SL, RD_SL_W, RD_SH, RD_SH_W
  } state_t;

  state_t      state;
  logic [31:0] load;
  logic        cont;
  logic        stop_pending;
  logic [15:0] snap_lo;
  logic [31:0] load_in;

  // Periods 0 and 1 both collapse to a zero load.
  assign load_in = (cmd_period == 32'd0) ? 32'd0 : cmd_period - 32'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      load           <= 32'd0;
      cont           <= 1'b0;
      stop_pending   <= 1'b0;
      snap_lo        <= 16'd0;
      avm_address    <= 3'd0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= 16'd0;
      busy           <= 1'b0;
      tick           <= 1'b0;
      tick_count     <= '0;
      snap_value     <= 32'd0;
      snap_valid     <= 1'b0;
    end else begin
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      tick           <= 1'b0;
      snap_valid     <= 1'b0;
      if (cmd_stop && state != IDLE) stop_pending <= 1'b1;

      // Bus outputs are set on the transition into each access state.
      case (state)
        IDLE: begin
          if (cmd_start) begin
            load           <= load_in;
            cont           <= cmd_continuous;
            tick_count     <= '0;
            stop_pending   <= 1'b0;
            busy           <= 1'b1;
            state          <= WR_PL;
            avm_address    <= 3'd2;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_writedata  <= load_in[15:0];
          end
        end
        WR_PL: begin
          state          <= WR_PH;
          avm_address    <= 3'd3;
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_writedata  <= load[31:16];
        end
        WR_PH: begin
          state          <= WR_CTL;
          avm_address    <= 3'd1;
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_writedata  <= {13'd0, 1'b1, cont, 1'b1};
        end
        WR_CTL: state <= RUN;
        RUN: begin
          if (timer_irq) begin
            state          <= WR_CLR;
            tick           <= 1'b1;
            tick_count     <= tick_count + 1'b1;
            avm_address    <= 3'd0;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_writedata  <= 16'd0;
          end else if (stop_pending) begin
            state          <= WR_STOP;
            avm_address    <= 3'd1;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_writedata  <= 16'h0008;
          end else if (cmd_snap) begin
            state          <= WR_SNAP;
            avm_address    <= 3'd4;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_writedata  <= 16'd0;
          end
        end
        WR_CLR: state <= CLR_WAIT;
        CLR_WAIT: begin
          // A one-shot timer has already stopped itself; a pending stop ends here too.
          if (!cont || stop_pending) begin
            state        <= IDLE;
            busy         <= 1'b0;
            stop_pending <= 1'b0;
          end else begin
            state <= RUN;
          end
        end
        WR_STOP: begin
          state        <= IDLE;
          busy         <= 1'b0;
          stop_pending <= 1'b0;
        end
        WR_SNAP: begin
          state          <= RD_SL;
          avm_address    <= 3'd4;
          avm_chipselect <= 1'b1;
        end
        RD_SL: state <= RD_SL_W;
        RD_SL_W: begin
          snap_lo        <= avm_readdata;
          state          <= RD_SH;
          avm_address    <= 3'd5;
          avm_chipselect <= 1'b1;
        end
        RD_SH: state <= RD_SH_W;
        RD_SH_W: begin
          snap_value <= {avm_readdata, snap_lo};
          snap_valid <= 1'b1;
          state      <= RUN;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_seq_master.sv
// Bench for timer_seq_master: behavioural interval-timer slave plus an
// expected-event scoreboard (bus accesses, ticks, snapshots) built from timing rules.
module tb_timer_seq_master;
  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, cmd_start, cmd_continuous, cmd_stop, cmd_snap;
  logic [31:0]   cmd_period;
  logic [2:0]    avm_address;
  logic          avm_chipselect, avm_write_n;
  logic [15:0]   avm_writedata, avm_readdata;
  logic          timer_irq, busy, tick, snap_valid;
  logic [TW-1:0] tick_count;
  logic [31:0]   snap_value;

  timer_seq_master #(.TICK_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_period(cmd_period),
    .cmd_continuous(cmd_continuous), .cmd_stop(cmd_stop), .cmd_snap(cmd_snap),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .timer_irq(timer_irq),
    .busy(busy), .tick(tick), .tick_count(tick_count), .snap_value(snap_value),
    .snap_valid(snap_valid)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    n_chk = 0, n_fail = 0;
  string scen = "reset";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL [%s] %s: got 0x%0h, expected 0x%0h (cycle %0d)", scen, tag, got, exp, cyc);
    end
  endtask

  // Interval timer slave: counter reloads from period, timeout every load+1 cycles.
  logic        tmr_rst_n;
  logic [31:0] t_load, t_cnt, t_snap;
  logic        t_run, t_cont, t_to, t_ito;
  assign timer_irq = t_to & t_ito;

  always @(posedge clk or negedge tmr_rst_n) begin
    if (!tmr_rst_n) begin
      t_load <= 0; t_cnt <= 0; t_snap <= 0; t_run <= 0; t_cont <= 0;
      t_to <= 0; t_ito <= 0; avm_readdata <= 0;
    end else begin
      if (t_run) begin
        if (t_cnt == 0) begin
          t_to  <= 1'b1;
          t_cnt <= t_load;
          if (!t_cont) t_run <= 1'b0;
        end else begin
          t_cnt <= t_cnt - 1;
        end
      end
      avm_readdata <= 16'h0;
      if (avm_chipselect && !avm_write_n) begin
        case (avm_address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            if (avm_writedata[3]) t_run <= 1'b0;
            else if (avm_writedata[0]) begin t_run <= 1'b1; t_cnt <= t_load; end
            t_cont <= avm_writedata[1];
            t_ito  <= avm_writedata[2];
          end
          3'd2: t_load[15:0]  <= avm_writedata;
          3'd3: t_load[31:16] <= avm_writedata;
          3'd4: t_snap <= t_cnt;
          default: ;
        endcase
      end else if (avm_chipselect) begin
        if (avm_address == 3'd4) avm_readdata <= t_snap[15:0];
        else if (avm_address == 3'd5) avm_readdata <= t_snap[31:16];
      end
    end
  end

  typedef struct { int cyc; int addr; int wr; int data; } ev_t;
  typedef struct { int cyc; int val; } pt_t;
  ev_t exp_bus[$], got_bus[$];
  pt_t exp_tick[$], got_tick[$], exp_snap[$], got_snap[$];

  always begin : monitor
    ev_t e;
    pt_t p;
    @(posedge clk);
    #1;
    if (avm_chipselect) begin
      e.cyc = cyc; e.addr = int'(avm_address); e.wr = int'(!avm_write_n);
      e.data = int'(avm_writedata);
      got_bus.push_back(e);
    end else begin
      chk("write_n_when_idle", 32'(avm_write_n), 32'd1);
    end
    if (tick) begin p.cyc = cyc; p.val = int'(tick_count); got_tick.push_back(p); end
    if (snap_valid) begin p.cyc = cyc; p.val = int'(snap_value); got_snap.push_back(p); end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_cyc(input int c);
    if (cyc > c) chk("schedule", cyc, c);
    while (cyc < c) step(1);
  endtask

  task automatic push_bus(input int c, input int a, input int w, input int d);
    ev_t e;
    e.cyc = c; e.addr = a; e.wr = w; e.data = d;
    exp_bus.push_back(e);
  endtask

  task automatic add_tick(input int t, input int k);
    pt_t p;
    p.cyc = t; p.val = k % (1 << TW);
    exp_tick.push_back(p);
    push_bus(t, 0, 1, 0);
  endtask

  task automatic compare();
    int n;
    chk("bus_count", got_bus.size(), exp_bus.size());
    n = (got_bus.size() < exp_bus.size()) ? got_bus.size() : exp_bus.size();
    for (int i = 0; i < n; i++) begin
      chk("bus_cycle", got_bus[i].cyc, exp_bus[i].cyc);
      chk("bus_addr", got_bus[i].addr, exp_bus[i].addr);
      chk("bus_is_write", got_bus[i].wr, exp_bus[i].wr);
      if (exp_bus[i].wr == 1) chk("bus_wdata", got_bus[i].data, exp_bus[i].data);
    end
    chk("tick_count_events", got_tick.size(), exp_tick.size());
    n = (got_tick.size() < exp_tick.size()) ? got_tick.size() : exp_tick.size();
    for (int i = 0; i < n; i++) begin
      chk("tick_cycle", got_tick[i].cyc, exp_tick[i].cyc);
      chk("tick_count", got_tick[i].val, exp_tick[i].val);
    end
    chk("snap_events", got_snap.size(), exp_snap.size());
    n = (got_snap.size() < exp_snap.size()) ? got_snap.size() : exp_snap.size();
    for (int i = 0; i < n; i++) begin
      chk("snap_cycle", got_snap[i].cyc, exp_snap[i].cyc);
      chk("snap_value", got_snap[i].val, exp_snap[i].val);
    end
    exp_bus.delete(); got_bus.delete(); exp_tick.delete(); got_tick.delete();
    exp_snap.delete(); got_snap.delete();
  endtask

  // Issues cmd_start in the current cycle; WR_PL/WR_PH/WR_CTL follow on cycles +1..+3.
  task automatic start_prog(input logic [31:0] p, input logic cont, input bit expect_ctl,
                            output int ctl);
    int c0;
    logic [31:0] ld;
    c0 = cyc;
    ld = (p == 0) ? 32'd0 : p - 1;
    cmd_start = 1; cmd_period = p; cmd_continuous = cont;
    step(1);
    cmd_start = 0;
    chk("busy_after_start", 32'(busy), 32'd1);
    push_bus(c0 + 1, 2, 1, int'(ld[15:0]));
    push_bus(c0 + 2, 3, 1, int'(ld[31:16]));
    if (expect_ctl) push_bus(c0 + 3, 1, 1, cont ? 7 : 5);
    ctl = c0 + 3;
  endtask

  task automatic stop_from_run(input int c);
    wait_cyc(c);
    cmd_stop = 1; step(1); cmd_stop = 0;
    push_bus(c + 2, 1, 1, 8);
    wait_cyc(c + 3);
    chk("busy_after_stop", 32'(busy), 32'd0);
  endtask

  // Snapshot requested two cycles after a tick; counter value follows from elapsed time.
  task automatic snap_at(input int t, input int ctl, input int p);
    int s;
    pt_t e;
    s = t + 3;
    wait_cyc(t + 2);
    cmd_snap = 1; step(1); cmd_snap = 0;
    push_bus(s, 4, 1, 0); push_bus(s + 1, 4, 0, 0); push_bus(s + 3, 5, 0, 0);
    e.cyc = s + 5;
    e.val = (p - 1) - ((s - (ctl + 1)) % p);
    exp_snap.push_back(e);
  endtask

  task automatic check_reset_vals();
    chk("rst_address", 32'(avm_address), 0);
    chk("rst_chipselect", 32'(avm_chipselect), 0);
    chk("rst_write_n", 32'(avm_write_n), 1);
    chk("rst_writedata", 32'(avm_writedata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_tick_count", 32'(tick_count), 0);
    chk("rst_snap_value", snap_value, 0);
    chk("rst_snap_valid", 32'(snap_valid), 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ctl, p, n, t, s;
    reset_n = 0; tmr_rst_n = 0;
    cmd_start = 0; cmd_period = 0; cmd_continuous = 0; cmd_stop = 0; cmd_snap = 0;
    step(3);
    check_reset_vals();
    reset_n = 1; tmr_rst_n = 1;
    step(3);

    scen = "cont_100";
    start_prog(100, 1, 1, ctl);
    for (int k = 1; k <= 3; k++) add_tick(ctl + 2 + k * 100, k);
    stop_from_run(ctl + 2 + 3 * 100 + 2);
    step(5); compare();

    for (int it = 0; it < 3; it++) begin
      scen = $sformatf("rand_cont_%0d", it);
      p = $urandom_range(60, 16);
      n = $urandom_range(5, 2);
      start_prog(p, 1, 1, ctl);
      if (it == 0) begin
        wait_cyc(ctl + 1);
        cmd_start = 1; cmd_period = $urandom; cmd_continuous = 0;
        step(1);
        cmd_start = 0;
      end
      for (int k = 1; k <= n; k++) begin
        t = ctl + 2 + k * p;
        add_tick(t, k);
        if (k < n && $urandom_range(1, 0) == 1) snap_at(t, ctl, p);
        if (k == n) stop_from_run(t + 2);
      end
      step(5); compare();
    end

    scen = "oneshot_big";
    start_prog(32'h0002_0000, 0, 1, ctl);
    stop_from_run(ctl + 1);
    step(5); compare();

    scen = "oneshot_rand";
    p = $urandom_range(60, 16);
    start_prog(p, 0, 1, ctl);
    t = ctl + 2 + p;
    add_tick(t, 1);
    wait_cyc(t + 2);
    chk("busy_after_oneshot", 32'(busy), 0);
    step(3 * p); compare();

    for (int pz = 0; pz < 2; pz++) begin
      scen = $sformatf("oneshot_period_%0d", pz);
      start_prog(pz, 0, 1, ctl);
      t = ctl + 3;
      add_tick(t, 1);
      wait_cyc(t + 2);
      chk("busy_after_oneshot", 32'(busy), 0);
      step(10); compare();
    end

    scen = "snap_in_idle";
    cmd_snap = 1; step(1); cmd_snap = 0;
    step(10);
    chk("busy_idle", 32'(busy), 0);
    compare();

    scen = "snap_12345";
    p = 32'h0001_2346 + 10;
    start_prog(p, 1, 1, ctl);
    snap_at(ctl + 8, ctl, p);
    s = ctl + 11;
    wait_cyc(s + 6);
    chk("snap_value_12345", snap_value, 32'h0001_2345);
    stop_from_run(s + 6);
    step(5); compare();

    scen = "stop_with_irq";
    p = $urandom_range(60, 16);
    start_prog(p, 1, 1, ctl);
    wait_cyc(ctl + p + 1);
    cmd_stop = 1; step(1); cmd_stop = 0;
    t = ctl + p + 2;
    add_tick(t, 1);
    wait_cyc(t + 2);
    chk("busy_after_stop_irq", 32'(busy), 0);
    p = $urandom_range(60, 16);
    start_prog(p, 1, 1, ctl);
    for (int k = 1; k <= 2; k++) add_tick(ctl + 2 + k * p, k);
    stop_from_run(ctl + 2 + 2 * p + 2);
    step(5); compare();

    scen = "tick_wrap";
    start_prog(16, 1, 1, ctl);
    for (int k = 1; k <= 18; k++) add_tick(ctl + 2 + k * 16, k);
    stop_from_run(ctl + 2 + 18 * 16 + 2);
    step(5); compare();

    scen = "reset_mid";
    start_prog(200, 1, 0, ctl);
    step(1);
    #2;
    reset_n = 0;
    #1;
    check_reset_vals();
    step(3);
    reset_n = 1;
    step(5);
    chk("timer_not_started", 32'(t_run), 0);
    compare();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
